// File: rtl/test_end_monitor_if.sv
// Register-file snoop bus, control and status of the end-of-test monitor.
interface test_end_monitor_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              start;
  logic              clear;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [DATA_W-1:0] fail_testnum;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [2:0]        state;

  modport master (
    output start, clear, we, waddr, wdata,
    input  done, pass, fail, timeout, fail_testnum, cycle_cnt, state
  );

  modport slave (
    input  start, clear, we, waddr, wdata,
    output done, pass, fail, timeout, fail_testnum, cycle_cnt, state
  );
endinterface

// File: rtl/test_end_monitor.sv
// End-of-test detector: snoops register-file writes for done/pass/test-number
// registers and reports PASS, FAIL or TIMEOUT after a settle window.
module test_end_monitor #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned PASS_REG       = 27,
  parameter int unsigned NUM_REG        = 3,
  parameter int unsigned SETTLE_CYCLES  = 5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  test_end_monitor_if.slave bus
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] DONE_A    = ADDR_W'(DONE_REG);
  localparam logic [ADDR_W-1:0] PASS_A    = ADDR_W'(PASS_REG);
  localparam logic [ADDR_W-1:0] NUM_A     = ADDR_W'(NUM_REG);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SETTLE = 3'd2,
    S_PASS   = 3'd3,
    S_FAIL   = 3'd4,
    S_TOUT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [DATA_W-1:0] done_sh_q, done_sh_d;
  logic [DATA_W-1:0] pass_sh_q, pass_sh_d;
  logic [DATA_W-1:0] num_sh_q, num_sh_d;
  logic [DATA_W-1:0] testnum_q, testnum_d;
  logic              done_q, pass_q, fail_q, tout_q;
  logic              snoop;

  // State register plus the registered status outputs decoded from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      settle_q  <= '0;
      done_sh_q <= '0;
      pass_sh_q <= '0;
      num_sh_q  <= '0;
      testnum_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      done_sh_q <= done_sh_d;
      pass_sh_q <= pass_sh_d;
      num_sh_q  <= num_sh_d;
      testnum_q <= testnum_d;
      done_q    <= (state_d == S_PASS) || (state_d == S_FAIL);
      pass_q    <= (state_d == S_PASS);
      fail_q    <= (state_d == S_FAIL);
      tout_q    <= (state_d == S_TOUT);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    done_sh_d = done_sh_q;
    pass_sh_d = pass_sh_q;
    num_sh_d  = num_sh_q;
    testnum_d = testnum_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Writes only count while a test is live; x0 can never be a watched register.
    snoop = ((state_q == S_RUN) || (state_q == S_SETTLE)) && bus.we && (bus.waddr != '0);
    if (snoop && (bus.waddr == DONE_A)) done_sh_d = bus.wdata;
    if (snoop && (bus.waddr == PASS_A)) pass_sh_d = bus.wdata;
    if (snoop && (bus.waddr == NUM_A))  num_sh_d  = bus.wdata;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (done_sh_q == ONE) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end else if (cnt_inc >= TOUT_LAST) begin
          state_d   = S_TOUT;
          testnum_d = num_sh_q;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_inc;
        if (settle_q == SET_LAST) begin
          if (pass_sh_q == ONE) begin
            state_d = S_PASS;
          end else begin
            state_d   = S_FAIL;
            testnum_d = num_sh_q;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_PASS, S_FAIL, S_TOUT: ;
      default: state_d = S_IDLE;
    endcase

    // Restart wins over everything else in the same cycle.
    if (bus.clear) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      settle_d  = '0;
      done_sh_d = '0;
      pass_sh_d = '0;
      num_sh_d  = '0;
      testnum_d = '0;
    end
  end

  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.timeout      = tout_q;
  assign bus.fail_testnum = testnum_q;
  assign bus.cycle_cnt    = cnt_q;
  assign bus.state        = 3'(state_q);

endmodule

// File: tb/tb_test_end_monitor.sv
// Scoreboard bench for test_end_monitor: each test pushes its expected verdict,
// popped and compared when the monitor reaches a terminal status.
module tb_test_end_monitor;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SETTLE = 5;
  localparam int unsigned TOUT   = 100;

  typedef struct {
    string       name;
    int unsigned st;
    int unsigned tnum;
    int unsigned cnt;
    int unsigned end_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];

  test_end_monitor_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  test_end_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DONE_REG(26), .PASS_REG(27), .NUM_REG(3),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TOUT), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int unsigned a, input int unsigned d, input logic en = 1'b1);
    bus.we    = en;
    bus.waddr = ADDR_W'(a);
    bus.wdata = DATA_W'(d);
    tick();
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
  endtask

  task automatic start_test();
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_test();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_state"}, 64'(bus.state), 64'd0);
    chk({tag, "_flags"}, 64'({bus.done, bus.pass, bus.fail, bus.timeout}), 64'd0);
    chk({tag, "_tnum"}, 64'(bus.fail_testnum), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.cycle_cnt), 64'd0);
  endtask

  // Run until a terminal status appears (bounded), then score against the queue head.
  task automatic wait_end(input int budget);
    exp_t e;
    int   n = 0;
    while (!(bus.done || bus.timeout) && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    if (!(bus.done || bus.timeout)) begin
      chk({e.name, "_no_end"}, 64'd0, 64'd1);
      return;
    end
    chk({e.name, "_state"}, 64'(bus.state), 64'(e.st));
    chk({e.name, "_done"}, 64'(bus.done), 64'((e.st == 3) || (e.st == 4)));
    chk({e.name, "_pass"}, 64'(bus.pass), 64'(e.st == 3));
    chk({e.name, "_fail"}, 64'(bus.fail), 64'(e.st == 4));
    chk({e.name, "_tout"}, 64'(bus.timeout), 64'(e.st == 5));
    chk({e.name, "_tnum"}, 64'(bus.fail_testnum), 64'(e.tnum));
    chk({e.name, "_cnt"}, 64'(bus.cycle_cnt), 64'(e.cnt));
    chk({e.name, "_cyc"}, 64'(cyc), 64'(e.end_cyc));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    idle(3);
    chk_quiet("rst");
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    chk_quiet("post_rst");

    // PASS: x27=1 early, x26=1 at cycle 10 -> SETTLE at 12, PASS at 17.
    start_test();
    chk("t1_run", 64'(bus.state), 64'd1);
    idle(2);
    wr(27, 1);
    idle(6);
    wr(26, 1);
    chk("t1_c11", 64'(bus.state), 64'd1);
    tick();
    chk("t1_c12", 64'(bus.state), 64'd2);
    idle(4);
    chk("t1_c16", 64'(bus.state), 64'd2);
    chk("t1_c16_done", 64'(bus.done), 64'd0);
    sb.push_back('{"t1", 3, 0, 10 + 1 + SETTLE, 10 + 2 + SETTLE});
    wait_end(40);
    idle(3);
    chk("t1_sticky", 64'(bus.pass), 64'd1);
    chk("t1_frozen", 64'(bus.cycle_cnt), 64'(10 + 1 + SETTLE));
    clear_test();
    chk_quiet("t1_clr");

    // FAIL with test number 7.
    start_test();
    wr(27, 0);
    wr(3, 7);
    wr(26, 1);
    sb.push_back('{"t2", 4, 7, 3 + 1 + SETTLE, 3 + 2 + SETTLE});
    wait_end(40);
    clear_test();
    chk_quiet("t2_clr");

    // TIMEOUT: x26=2 is not DONE, we=0 write to x26 is ignored; testnum from x3.
    start_test();
    wr(3, 5);
    wr(26, 2);
    wr(26, 1, 1'b0);
    sb.push_back('{"t3", 5, 5, TOUT - 1, TOUT});
    wait_end(TOUT + 20);
    idle(5);
    chk("t3_frozen", 64'(bus.cycle_cnt), 64'(TOUT - 1));
    chk("t3_sticky", 64'(bus.state), 64'd5);
    clear_test();
    chk_quiet("t3_clr");

    // Late PASS write inside the settle window still counts.
    start_test();
    wr(26, 1);
    idle(1);
    wr(27, 1);
    sb.push_back('{"t4", 3, 0, 1 + 1 + SETTLE, 1 + 2 + SETTLE});
    wait_end(40);
    clear_test();

    // Writes in IDLE are ignored, so x27 stays 0 and the test FAILs.
    wr(26, 1);
    wr(27, 1);
    wr(3, 9);
    chk("t5_idle", 64'(bus.state), 64'd0);
    start_test();
    wr(26, 1);
    sb.push_back('{"t5", 4, 0, 1 + 1 + SETTLE, 1 + 2 + SETTLE});
    wait_end(40);
    clear_test();

    // clear beats start in IDLE; clear during SETTLE aborts the test.
    bus.start = 1'b1;
    clear_test();
    bus.start = 1'b0;
    chk("t6_clr_prio", 64'(bus.state), 64'd0);
    start_test();
    wr(27, 1);
    wr(26, 1);
    tick();
    chk("t6_settle", 64'(bus.state), 64'd2);
    clear_test();
    chk_quiet("t6_clr");
    idle(10);
    chk("t6_stay_idle", 64'(bus.state), 64'd0);

    // Asynchronous reset in the middle of RUN.
    start_test();
    wr(3, 4);
    idle(4);
    chk("t7_run", 64'(bus.state), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk_quiet("t7_async");
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    chk_quiet("t7_after");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end
endmodule
